// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the multiply sequencer state type.
package cpu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ABS_M,
    ABS_Q,
    MUL,
    NEG_LO,
    NEG_HI,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result and shared-ALU signals of the MULT/MULTU sequencer.
interface mul_seq_if #(
  parameter int WIDTH = 32
) ();

  // start is sampled only while busy=0 (IDLE); once accepted, busy stays high
  // until the cycle after the single-cycle done pulse, when hi/lo hold the product.
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Shared ALU: mul_seq owns the ALU inputs whenever alu_req=1.
  logic             alu_req;
  logic [2:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output start, is_signed, op_a, op_b, alu_result,
    input  busy, done, hi, lo, alu_req, alu_ctl, alu_a, alu_b
  );

  modport slave (
    input  start, is_signed, op_a, op_b, alu_result,
    output busy, done, hi, lo, alu_req, alu_ctl, alu_a, alu_b
  );

endinterface

// File: rtl/mul_seq.sv
// Multi-cycle MULT/MULTU sequencer: shift-add multiply through the shared ALU,
// with optional sign fix-up, writing the 64-bit product into HI/LO.
module mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  mul_seq_if.slave   bus,
  output mul_state_t dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  mul_state_t       state;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             sgn;
  logic             borrow;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       ctl;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry;

  // ALU operands are a pure function of state so the result arrives in-cycle.
  always_comb begin
    ctl  = ALU_AND;
    a_in = '0;
    b_in = '0;
    case (state)
      ABS_M: begin
        ctl  = ALU_SUB;
        b_in = m_q;
      end
      ABS_Q: begin
        ctl  = ALU_SUB;
        b_in = lo_q;
      end
      MUL: begin
        ctl  = ALU_ADD;
        a_in = hi_q;
        b_in = lo_q[0] ? m_q : '0;
      end
      NEG_LO: begin
        ctl  = ALU_SUB;
        b_in = lo_q;
      end
      NEG_HI: begin
        ctl  = ALU_ADD;
        a_in = ~hi_q;
        b_in = borrow ? '0 : ONE;
      end
      default: begin
        ctl  = ALU_AND;
        a_in = '0;
        b_in = '0;
      end
    endcase
  end

  // An unsigned add wrapped exactly when its result is below an operand.
  assign carry = (bus.alu_result < hi_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sgn    <= 1'b0;
      borrow <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_q    <= bus.op_a;
            lo_q   <= bus.op_b;
            hi_q   <= '0;
            cnt    <= '0;
            neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            sgn    <= bus.is_signed;
            busy_q <= 1'b1;
            state  <= bus.is_signed ? ABS_M : MUL;
          end
        end
        ABS_M: begin
          if (m_q[WIDTH-1]) m_q <= bus.alu_result;
          state <= ABS_Q;
        end
        ABS_Q: begin
          if (lo_q[WIDTH-1]) lo_q <= bus.alu_result;
          state <= MUL;
        end
        MUL: begin
          hi_q <= {carry, bus.alu_result[WIDTH-1:1]};
          lo_q <= {bus.alu_result[0], lo_q[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (sgn) begin
              state <= NEG_LO;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        NEG_LO: begin
          // Negation is only committed when the signs differed; the slot is
          // always spent so signed latency does not depend on the operands.
          if (neg) begin
            lo_q   <= bus.alu_result;
            borrow <= (lo_q != '0);
          end
          state <= NEG_HI;
        end
        NEG_HI: begin
          if (neg) hi_q <= bus.alu_result;
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.alu_req = busy_q & ~done_q;
  assign bus.alu_ctl = ctl;
  assign bus.alu_a   = a_in;
  assign bus.alu_b   = b_in;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: a product/latency model checked every cycle,
// plus hand-computed products for each directed vector.
module tb_mul_seq;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  mul_state_t dbg_state;

  mul_seq_if #(.WIDTH(32)) bus ();

  mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Shared CPU ALU, combinational.
  always_comb begin
    case (bus.alu_ctl)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SRL: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      ALU_SLL: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_SLT: bus.alu_result = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      default: bus.alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [63:0] exp_q[$];
  bit          m_live = 0;
  bit          m_busy;
  bit          m_sgn;
  bit          m_have;
  int          m_n;
  int          m_lat;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Expected ALU opcode n cycles after acceptance (cycle 1 = first busy cycle).
  function automatic logic [2:0] phase_ctl(input bit s, input int n);
    if (!s) return (n <= 32) ? ALU_ADD : ALU_AND;
    if (n <= 2) return ALU_SUB;
    if (n <= 34) return ALU_ADD;
    if (n == 35) return ALU_SUB;
    if (n == 36) return ALU_ADD;
    return ALU_AND;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1;
      m_busy = 0;
      m_n    = 0;
      m_have = 1;
      m_hi   = '0;
      m_lo   = '0;
      exp_q.delete();
    end else if (m_live) begin
      if (m_busy) begin
        if (m_n == m_lat) m_busy = 0;
        else m_n++;
      end else if (bus.start) begin
        m_busy = 1;
        m_n    = 1;
        m_sgn  = bus.is_signed;
        m_lat  = bus.is_signed ? 37 : 33;
        m_have = 0;
        exp_q.push_back(product(bus.op_a, bus.op_b, bus.is_signed));
      end
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    logic [63:0] p;
    bit          in_done;
    if (m_live) begin
      in_done = m_busy && (m_n == m_lat);
      if (in_done && exp_q.size() > 0) begin
        p = exp_q.pop_front();
        m_hi = p[63:32];
        m_lo = p[31:0];
        m_have = 1;
      end
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(in_done));
      check("alu_req", 64'(bus.alu_req), 64'(m_busy && !in_done));
      if (m_busy) check("alu_ctl phase", 64'(bus.alu_ctl), 64'(phase_ctl(m_sgn, m_n)));
      if (!bus.alu_req) begin
        check("idle alu_ctl", 64'(bus.alu_ctl), 64'(ALU_AND));
        check("idle alu_a", 64'(bus.alu_a), 64'd0);
        check("idle alu_b", 64'(bus.alu_b), 64'd0);
      end else if (bus.alu_ctl == ALU_SUB) begin
        check("sub alu_a", 64'(bus.alu_a), 64'd0);
      end
      if (m_have) begin
        check("hi", 64'(bus.hi), 64'(m_hi));
        check("lo", 64'(bus.lo), 64'(m_lo));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.is_signed = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Caller sits in cycle first_n after the sampling edge, before its negedge.
  task automatic wait_done(input int first_n, input int lat, input logic [31:0] eh,
                           input logic [31:0] el, input string name);
    bit seen = 0;
    int at = 0;
    for (int n = first_n; n <= lat + 10 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        at = n;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, lat + 10);
    end else begin
      check({name, " latency"}, 64'(at), 64'(lat));
      check({name, " hi"}, 64'(bus.hi), 64'(eh));
      check({name, " lo"}, 64'(bus.lo), 64'(el));
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    issue_start(a, b, s);
    wait_done(1, s ? 37 : 33, eh, el, name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset alu_req", 64'(bus.alu_req), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset state", 64'(dbg_state), 64'(IDLE));

    run_op(32'd3, 32'd5, 1'b0, 32'h0000_0000, 32'h0000_000F, "u 3*5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "u max*max");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "s -3*5");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, "s min*min");
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, "s -1*0");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'hC000_0000, 32'h8000_0000, "s max*min");
    run_op(32'd5, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFDD, "s 5*-7");

    // Start pulsed while busy must be ignored; next start right after DONE.
    issue_start(32'd7, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.op_a      = 32'd2;
    bus.op_b      = 32'd2;
    bus.is_signed = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(11, 33, 32'd0, 32'd63, "u 7*9 busy-start");
    issue_start(32'd6, 32'd7, 1'b0);
    wait_done(1, 33, 32'd0, 32'd42, "u 6*7 back-to-back");

    // Reset in the middle of a signed operation.
    issue_start(32'hFFFF_FFFD, 32'd5, 1'b1);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst alu_req", 64'(bus.alu_req), 64'd0);
    check("midrst hi", 64'(bus.hi), 64'd0);
    check("midrst lo", 64'(bus.lo), 64'd0);
    check("midrst state", 64'(dbg_state), 64'(IDLE));
    dones = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst no done", 64'(dones), 64'd0);

    run_op(32'd1000, 32'd1000, 1'b0, 32'd0, 32'd1000000, "u after reset");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
